// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial A - B - bin with per-nibble carry select and valid/ready on both sides.
// Define SUBTRACTOR_OVF_EN to compute signed overflow; otherwise ovf_o is tied low.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  nb_q, nb_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;

    logic [3:0] nib_a, nib_nb;
    logic [4:0] sum0, sum1, nib_sel;
    logic       last_nib;

    // Both candidate sums are formed in parallel; the registered carry only drives the mux.
    assign nib_a    = a_q[idx_q*4 +: 4];
    assign nib_nb   = nb_q[idx_q*4 +: 4];
    assign sum0     = {1'b0, nib_a} + {1'b0, nib_nb};
    assign sum1     = {1'b0, nib_a} + {1'b0, nib_nb} + 5'd1;
    assign nib_sel  = carry_q ? sum1 : sum0;
    assign last_nib = (idx_q == IdxW'(NIB - 1));

`ifdef SUBTRACTOR_OVF_EN
    logic ovf_q, ovf_d;
    // nb_q holds ~b, so equal MSBs here mean the operand signs differ.
    assign ovf_d = (state_q == StRun && last_nib)
                   ? ((a_q[WIDTH-1] == nb_q[WIDTH-1]) && (nib_sel[3] != a_q[WIDTH-1]))
                   : ovf_q;
    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        nb_d        = nb_q;
        carry_d     = carry_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    nb_d    = ~b_i;
                    carry_d = ~bin_i;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                diff_d[idx_q*4 +: 4] = nib_sel[3:0];
                carry_d              = nib_sel[4];
                if (last_nib) begin
                    bout_d  = ~nib_sel[4];
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            nb_q    <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SUBTRACTOR_OVF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    assign diff_o = diff_q;
    assign bout_o = bout_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH = 16): directed table,
// backpressure, mid-run reset and back-to-back random operations against an arithmetic model.
module tb_nibble_serial_subtractor;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;
`ifdef SUBTRACTOR_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .bin_i       (bin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .diff_o      (diff),
        .bout_o      (bout),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic         exp_ovf_raw;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain wide integer subtraction; the borrow is the sign of the widened result.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] md, output logic mbo, output logic mov);
        logic [W:0] full;
        full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        md   = full[W-1:0];
        mbo  = full[W];
        mov  = OVF_ON && (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and returns once out_valid is seen (or the bound expires).
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         output int lat);
        a        = ia;
        b        = ib;
        bin      = ibin;
        in_valid = 1'b1;
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        bin      = $urandom_range(1);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_retire", {31'b0, out_valid}, 32'd0);
        check("in_ready_after_retire", {31'b0, in_ready}, 32'd1);
    endtask

    vec_t         vecs[7];
    int           lat;
    logic [W-1:0] md, hold_diff;
    logic         mbo, mov;

    initial begin
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_diff", {16'b0, diff}, 32'd0);
        check("reset_bout", {31'b0, bout}, 32'd0);
        check("reset_ovf", {31'b0, ovf}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            check($sformatf("vec%0d_latency", i), lat, NIB);
            check($sformatf("vec%0d_diff", i), {16'b0, diff}, {16'b0, vecs[i].exp_diff});
            check($sformatf("vec%0d_bout", i), {31'b0, bout}, {31'b0, vecs[i].exp_bout});
            check($sformatf("vec%0d_ovf", i), {31'b0, ovf},
                  {31'b0, vecs[i].exp_ovf_raw & OVF_ON});
            retire();
        end

        // Backpressure: result must freeze and new operands must be refused while held.
        issue(16'h4321, 16'h0123, 1'b0, lat);
        hold_diff = diff;
        check("bp_diff", {16'b0, diff}, 32'h41FE);
        a        = 16'hFFFF;
        b        = 16'h0000;
        bin      = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            check("bp_diff_stable", {16'b0, diff}, {16'b0, hold_diff});
        end
        in_valid = 1'b0;
        retire();
        check("bp_diff_held_idle", {16'b0, diff}, {16'b0, hold_diff});
        tick();
        check("bp_no_stray_accept", {31'b0, in_ready}, 32'd1);

        // Reset while idx = 2
        a        = 16'h1111;
        b        = 16'h2222;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        repeat (NIB + 2) begin
            tick();
            check("rst_no_result", {31'b0, out_valid}, 32'd0);
        end
        issue(16'hFFFF, 16'hFFFF, 1'b0, lat);
        check("post_rst_latency", lat, NIB);
        check("post_rst_diff", {16'b0, diff}, 32'd0);
        check("post_rst_bout", {31'b0, bout}, 32'd0);
        retire();

        // Back-to-back random with out_ready tied high; in_valid left high throughout.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            int           cyc;
            ra   = $urandom;
            rb   = $urandom;
            rbin = $urandom_range(1);
            if (i % 10 == 0) rb = ra;
            a    = ra;
            b    = rb;
            bin  = rbin;
            check("rnd_in_ready", {31'b0, in_ready}, 32'd1);
            tick();
            a   = $urandom;
            b   = $urandom;
            bin = $urandom_range(1);
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            model(ra, rb, rbin, md, mbo, mov);
            check($sformatf("rnd%0d_diff", i), {16'b0, diff}, {16'b0, md});
            check($sformatf("rnd%0d_bout", i), {31'b0, bout}, {31'b0, mbo});
            check($sformatf("rnd%0d_ovf", i), {31'b0, ovf}, {31'b0, mov});
            tick();
            cyc++;
            check($sformatf("rnd%0d_accept_to_retire", i), cyc, NIB + 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
